// File: rtl/uop_pkg.sv
// Shared constants and helpers for the microcode sequencer (uop_sequencer, uop_ir).
package uop_pkg;

  localparam int unsigned OPCODE_W = 8;
  localparam int unsigned T_W      = 3;
  localparam int unsigned UWORD_W  = 16;
  localparam int unsigned END_BIT  = UWORD_W - 1;

  typedef logic [UWORD_W-1:0] uword_t;

  // Fixed fetch control words: T0 = PC->AR, T1 = MEM->IR bus drive + PC++
  localparam uword_t FETCH0 = 16'h0000;
  localparam uword_t FETCH1 = 16'h4102;

  typedef enum logic [1:0] {
    SEL_FETCH0,
    SEL_FETCH1,
    SEL_ROM
  } word_sel_e;

  function automatic logic is_fetch(input logic [T_W-1:0] t);
    return (t == '0) || (t == T_W'(1));
  endfunction

  function automatic word_sel_e word_sel(input logic [T_W-1:0] t);
    if (t == '0)        return SEL_FETCH0;
    if (t == T_W'(1))   return SEL_FETCH1;
    return SEL_ROM;
  endfunction

endpackage

// File: rtl/uop_ir.sv
// Instruction register with load enable; src forwards the incoming opcode while loading.
module uop_ir #(
  parameter int unsigned OPCODE_W = uop_pkg::OPCODE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [OPCODE_W-1:0] d,
  output logic [OPCODE_W-1:0] q,
  output logic [OPCODE_W-1:0] src
);

  logic [OPCODE_W-1:0] opcode_q;
  logic [OPCODE_W-1:0] opcode_d;

  always_comb begin
    opcode_d = opcode_q;
    if (load) opcode_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) opcode_q <= '0;
    else     opcode_q <= opcode_d;
  end

  assign q   = opcode_q;
  assign src = opcode_d;

endmodule

// File: rtl/uop_sequencer.sv
// Microcode sequencer: IR, ROM address {opcode, T}, registered control word, END -> t_reset.
// Optional runaway watchdog on `UOP_WATCHDOG_EN (fault tied 0 when undefined).
module uop_sequencer #(
  parameter int unsigned OPCODE_W = uop_pkg::OPCODE_W,
  parameter int unsigned T_W      = uop_pkg::T_W,
  parameter int unsigned UWORD_W  = uop_pkg::UWORD_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [T_W-1:0]          T,
  input  logic [15:0]             bus_in,
  input  logic [UWORD_W-1:0]      rom_data,
  output logic [OPCODE_W+T_W-1:0] rom_addr,
  output logic [UWORD_W-1:0]      uinstr,
  output logic [OPCODE_W-1:0]     opcode,
  output logic                    t_reset,
  output logic                    fault
);

  import uop_pkg::*;

  logic [UWORD_W-1:0]  uinstr_q;
  logic [UWORD_W-1:0]  uinstr_d;
  logic                ir_load;
  logic [OPCODE_W-1:0] opcode_src;
  logic                bus_unused;

  assign ir_load    = (uinstr_q == UWORD_W'(FETCH1));
  assign bus_unused = ^bus_in[15-OPCODE_W:0];

  uop_ir #(.OPCODE_W(OPCODE_W)) u_ir (
    .clk  (clk),
    .rst  (reset),
    .load (ir_load),
    .d    (bus_in[15 -: OPCODE_W]),
    .q    (opcode),
    .src  (opcode_src)
  );

  assign rom_addr = {opcode_src, T};
  assign t_reset  = uinstr_q[END_BIT] & ~is_fetch(T);
  assign uinstr   = uinstr_q;

  always_comb begin
    uinstr_d = rom_data;
    unique case (word_sel(T))
      SEL_FETCH0: uinstr_d = UWORD_W'(FETCH0);
      SEL_FETCH1: uinstr_d = UWORD_W'(FETCH1);
      SEL_ROM:    uinstr_d = rom_data;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) uinstr_q <= '0;
    else       uinstr_q <= uinstr_d;
  end

`ifdef UOP_WATCHDOG_EN
  logic           end_seen_q;
  logic           end_seen_d;
  logic [T_W-1:0] prev_t_q;
  logic           fault_q;
  logic           fault_d;

  // t_reset has normally dropped by the next posedge (counter clears on negedge),
  // so END is also captured from the word being registered.
  always_comb begin
    end_seen_d = end_seen_q | t_reset | (rom_data[END_BIT] & ~is_fetch(T));
    if (T == '0) end_seen_d = 1'b0;
    fault_d = fault_q | ((prev_t_q == '1) && (T == '0) && !end_seen_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      end_seen_q <= 1'b0;
      prev_t_q   <= '0;
      fault_q    <= 1'b0;
    end else begin
      end_seen_q <= end_seen_d;
      prev_t_q   <= T;
      fault_q    <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_uop_sequencer.sv
// Bench for uop_sequencer: per-instruction control-word sequences derived from a random ROM image.
module tb_uop_sequencer;
  import uop_pkg::*;

`ifdef UOP_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  T = 3'd0;
  logic [15:0] bus_in = 16'h0000;
  logic [15:0] rom_data;
  logic [10:0] rom_addr;
  logic [15:0] uinstr;
  logic [7:0]  opcode;
  logic        t_reset;
  logic        fault;

  logic [15:0] rom [0:2047];

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  exp_opcode = 8'h00;
  logic        exp_fault  = 1'b0;
  bit          pending_runaway = 1'b0;

  always #5 clk = ~clk;

  // T-state counter environment: increments on negedge, clears on t_reset or reset
  always @(negedge clk or posedge rst) begin
    if (rst)          T <= 3'd0;
    else if (t_reset) T <= 3'd0;
    else              T <= T + 3'd1;
  end

  assign rom_data = rom[rom_addr];

  uop_sequencer #(.OPCODE_W(8), .T_W(3), .UWORD_W(16)) dut (
    .clk      (clk),
    .reset    (rst),
    .T        (T),
    .bus_in   (bus_in),
    .rom_data (rom_data),
    .rom_addr (rom_addr),
    .uinstr   (uinstr),
    .opcode   (opcode),
    .t_reset  (t_reset),
    .fault    (fault)
  );

  task automatic fill_rom();
    for (int op = 0; op < 256; op++) begin
      int unsigned endpos;
      endpos = $urandom_range(2, 8);
      for (int t = 0; t < 8; t++) begin
        logic [15:0] w;
        w = 16'($urandom) & 16'h7FFF;
        if (w == FETCH1) w = w ^ 16'h0001;
        if (t == int'(endpos)) w = w | 16'h8000;
        rom[{8'(op), 3'(t)}] = w;
      end
    end
    rom[{8'hA5, 3'd2}] = 16'h8003;
    rom[{8'h01, 3'd2}] = 16'h8011;
    rom[{8'h02, 3'd2}] = 16'h8022;
    for (int t = 2; t < 8; t++) rom[{8'h3C, 3'(t)}] = 16'h0100 + 16'(t);
    for (int t = 2; t < 6; t++) rom[{8'h77, 3'(t)}] = 16'h1230 + 16'(t);
    rom[{8'h77, 3'd6}] = 16'h9236;
    rom[{8'h77, 3'd7}] = 16'h0007;
  endtask

  // One full instruction: expected words are FETCH0, FETCH1, then ROM words for T2 up to the first END (or T7)
  task automatic run_instr(input logic [7:0] op, input int unsigned abort_at);
    logic [15:0] words[$];
    int          last;
    logic [7:0]  src;
    logic [2:0]  nt;
    logic        exp_tr;
    last = 7;
    for (int t = 7; t >= 2; t--) if (rom[{op, 3'(t)}][15]) last = t;
    words.delete();
    words.push_back(FETCH0);
    words.push_back(FETCH1);
    for (int t = 2; t <= last; t++) words.push_back(rom[{op, 3'(t)}]);

    for (int i = 0; i <= last; i++) begin
      @(posedge clk); #1;
      if (i == 0 && pending_runaway && WD) exp_fault = 1'b1;
      if (i == 0) pending_runaway = 1'b0;
      if (i == 2) exp_opcode = op;
      exp_tr = (i >= 2) && words[i][15];
      total++;
      if (uinstr !== words[i]) begin
        bad++; $display("FAIL uinstr op=%h i=%0d: got %h want %h", op, i, uinstr, words[i]);
      end
      total++;
      if (opcode !== exp_opcode) begin
        bad++; $display("FAIL opcode op=%h i=%0d: got %h want %h", op, i, opcode, exp_opcode);
      end
      total++;
      if (t_reset !== exp_tr) begin
        bad++; $display("FAIL t_reset op=%h i=%0d: got %b want %b", op, i, t_reset, exp_tr);
      end
      total++;
      if (fault !== exp_fault) begin
        bad++; $display("FAIL fault op=%h i=%0d: got %b want %b", op, i, fault, exp_fault);
      end
      if (i == int'(abort_at)) begin
        rst = 1'b1;
        #1;
        total++;
        if ({uinstr, opcode, t_reset, fault} !== 26'h0) begin
          bad++; $display("FAIL async_reset: got uinstr=%h opcode=%h t_reset=%b fault=%b want all 0",
                          uinstr, opcode, t_reset, fault);
        end
        exp_opcode = 8'h00;
        exp_fault = 1'b0;
        pending_runaway = 1'b0;
        return;
      end
      if (i == 1) bus_in = {op, 8'($urandom)};
      else        bus_in = {op ^ 8'($urandom_range(1, 255)), 8'($urandom)};
      @(negedge clk); #1;
      src = (i == 1) ? op : exp_opcode;
      nt  = (i == last) ? 3'd0 : 3'(i + 1);
      total++;
      if (rom_addr !== {src, nt}) begin
        bad++; $display("FAIL rom_addr op=%h i=%0d: got %h want %h", op, i, rom_addr, {src, nt});
      end
    end
    pending_runaway = !rom[{op, 3'(last)}][15];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({uinstr, opcode, t_reset, fault} !== 26'h0) begin
      bad++; $display("FAIL reset_state: got uinstr=%h opcode=%h t_reset=%b fault=%b want all 0",
                      uinstr, opcode, t_reset, fault);
    end
    total++;
    if (rom_addr !== 11'h000) begin
      bad++; $display("FAIL reset_rom_addr: got %h want 000", rom_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch_forward();
    run_instr(8'hA5, 99);
  endtask

  task automatic test_back_to_back();
    run_instr(8'h01, 99);
    run_instr(8'h02, 99);
    run_instr(8'hA5, 99);
  endtask

  task automatic test_runaway();
    run_instr(8'h3C, 99);
    run_instr(8'hA5, 99);
    total++;
    if (fault !== WD) begin
      bad++; $display("FAIL fault_sticky: got %b want %b", fault, WD);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) run_instr(8'($urandom_range(0, 255)), 99);
  endtask

  task automatic test_reset_mid();
    run_instr(8'h77, 4);
    @(negedge clk); #2;
    rst = 1'b0;
    run_instr(8'hA5, 99);
    run_instr(8'h77, 99);
  endtask

  initial begin
    fill_rom();
    test_reset();
    test_fetch_forward();
    test_back_to_back();
    test_runaway();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
